// File: rtl/debug_hub_pkg.sv
`default_nettype none
// ============================================================================
// Module      : debug_hub_pkg
// Description : Shared definitions for the debug view hub.
//               - Push-button index assignments.
//               - Hex-to-7-segment decoder, active-high segments {g..a}.
//               - Blank segment pattern.
// Revision    : 1.0 - initial release
// ============================================================================
package debug_hub_pkg;

    localparam int NUM_BTN  = 5;
    localparam int BTN_STEP = 0;
    localparam int BTN_UP   = 1;
    localparam int BTN_DN   = 2;
    localparam int BTN_FRZ  = 3;
    localparam int BTN_SNAP = 4;

    // All segments off, active-high {g..a}
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Hex digit to active-high segments {g,f,e,d,c,b,a}
    function automatic logic [6:0] seg7(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h3F;
            4'h1:    seg = 7'h06;
            4'h2:    seg = 7'h5B;
            4'h3:    seg = 7'h4F;
            4'h4:    seg = 7'h66;
            4'h5:    seg = 7'h6D;
            4'h6:    seg = 7'h7D;
            4'h7:    seg = 7'h07;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h6F;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h7C;
            4'hC:    seg = 7'h39;
            4'hD:    seg = 7'h5E;
            4'hE:    seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce
// Description : Push-button conditioner: two-flop synchroniser, debouncer
//               and rising-edge detector.
//               The debounced level follows the synchronised input only after
//               DEBOUNCE consecutive cycles of disagreement; any agreeing cycle
//               restarts the count.
// Ports       : clk    in  system clock
//               resetn in  synchronous active-low reset
//               raw    in  asynchronous button input, active-high
//               level  out debounced level
//               rise   out one-cycle pulse on a 0->1 transition of level
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce #(
    parameter int DEBOUNCE = 1000000
) (
    input  logic clk,
    input  logic resetn,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int               CNT_W    = $clog2(DEBOUNCE + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

    logic             sync_1;
    logic             sync_2;
    logic             level_q;
    logic             level_d;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync_1  <= 1'b0;
            sync_2  <= 1'b0;
            level_q <= 1'b0;
            level_d <= 1'b0;
            cnt     <= '0;
            rise    <= 1'b0;
        end else begin
            sync_1  <= raw;
            sync_2  <= sync_1;
            level_d <= level_q;
            rise    <= level_q & ~level_d;
            if (sync_2 != level_q) begin
                // The DEBOUNCE-th disagreeing cycle commits the new level
                if (cnt == CNT_LAST) begin
                    level_q <= sync_2;
                    cnt     <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    assign level = level_q;

endmodule
`default_nettype wire

// File: rtl/debug_view_hub.sv
`default_nettype none
// ============================================================================
// Module      : debug_view_hub
// Description : Board debug console hub. Debounces five push-buttons into
//               step / channel up / channel down / freeze / snapshot commands
//               and scans the selected debug word (live or frozen snapshot)
//               onto an 8-digit multiplexed 7-segment display.
// Ports       : clk       in  system clock
//               resetn    in  synchronous active-low reset
//               debug_bus in  NUM_CH words, channel k at [k*DATA_W +: DATA_W]
//               button    in  raw push-buttons, active-high
//               step      out one-cycle pulse per step press
//               ch_sel    out selected channel
//               frozen    out 1 = display shows the snapshot
//               num_an    out digit enables, active-low one-hot
//               num_csn   out segments {dp,g..a}, active-low
// Revision    : 1.0 - initial release
// ============================================================================
module debug_view_hub
    import debug_hub_pkg::*;
#(
    parameter int NUM_CH   = 8,
    parameter int DATA_W   = 32,
    parameter int SCAN_DIV = 50000,
    parameter int DEBOUNCE = 1000000
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [NUM_CH*DATA_W-1:0]  debug_bus,
    input  logic [NUM_BTN-1:0]        button,
    output logic                      step,
    output logic [$clog2(NUM_CH)-1:0] ch_sel,
    output logic                      frozen,
    output logic [7:0]                num_an,
    output logic [7:0]                num_csn
);

    localparam int                CH_W      = $clog2(NUM_CH);
    localparam int                SCAN_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CH_W-1:0]   LAST_CH   = CH_W'(NUM_CH - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

    // ------------------------------------------------------------------
    // Button conditioning
    // ------------------------------------------------------------------
    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] cmd;

    generate
        for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
            btn_debounce #(
                .DEBOUNCE (DEBOUNCE)
            ) u_btn (
                .clk    (clk),
                .resetn (resetn),
                .raw    (button[i]),
                .level  (btn_level[i]),
                .rise   (cmd[i])
            );
        end
    endgenerate

    // Only the press edges drive the hub; the held levels are not needed here
    logic unused_levels;
    assign unused_levels = ^btn_level;

    // ------------------------------------------------------------------
    // Command handling
    // ------------------------------------------------------------------
    logic [NUM_CH*DATA_W-1:0] snapshot;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            step     <= 1'b0;
            ch_sel   <= '0;
            frozen   <= 1'b0;
            snapshot <= '0;
        end else begin
            step <= cmd[BTN_STEP];

            // Simultaneous up and down cancel out
            if (cmd[BTN_UP] && !cmd[BTN_DN]) begin
                ch_sel <= (ch_sel == LAST_CH) ? '0 : ch_sel + 1'b1;
            end else if (cmd[BTN_DN] && !cmd[BTN_UP]) begin
                ch_sel <= (ch_sel == '0) ? LAST_CH : ch_sel - 1'b1;
            end

            // Freeze toggle has priority over re-capture: entering freeze
            // captures once, leaving freeze discards a coincident snapshot.
            if (cmd[BTN_FRZ]) begin
                frozen <= ~frozen;
                if (!frozen) begin
                    snapshot <= debug_bus;
                end
            end else if (cmd[BTN_SNAP] && frozen) begin
                snapshot <= debug_bus;
            end
        end
    end

    // ------------------------------------------------------------------
    // View selection
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] sel_word;
    logic [31:0]       view;
    logic [2:0]        digit;
    logic [3:0]        nibble;

    always_comb begin
        sel_word = '0;
        if (frozen) begin
            sel_word = snapshot[int'(ch_sel) * DATA_W +: DATA_W];
        end else begin
            sel_word = debug_bus[int'(ch_sel) * DATA_W +: DATA_W];
        end
        // Zero extension makes digits beyond the word width read '0'
        view                = '0;
        view[DATA_W-1:0]    = sel_word;
        nibble              = view[{digit, 2'b00} +: 4];
    end

    // ------------------------------------------------------------------
    // Display scan
    // ------------------------------------------------------------------
    logic [SCAN_W-1:0] scan_cnt;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            scan_cnt <= '0;
            digit    <= '0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            digit    <= digit + 1'b1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    // Registered outputs follow the current digit by one cycle; the
    // selection is re-evaluated every cycle, so a channel or freeze change
    // appears on the next digit refresh without restarting the scan.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            num_an  <= 8'hFF;
            num_csn <= {1'b1, ~SEG_BLANK};
        end else begin
            num_an  <= ~(8'b1 << digit);
            num_csn <= {1'b1, ~seg7(nibble)};
        end
    end

endmodule
`default_nettype wire
